// File: rtl/neuron_fire_scheduler_if.sv
// Stimulus, ADC handshake and neuron-bus signals of neuron_fire_scheduler.
// master: the stimulus/ADC side. slave: the scheduler.
interface neuron_fire_scheduler_if;
  logic               req_n1;
  logic               req_n2;
  logic               adc_start;
  logic               adc_drdy;
  logic signed [11:0] adc_data;
  logic signed [11:0] neuron_12bit;
  logic               fireN1;
  logic               fireN2;
  logic               busy;
  logic               timeout_err;
  logic [2:0]         assoc_level;

  modport master (
    output req_n1, req_n2, adc_drdy, adc_data,
    input  adc_start, neuron_12bit, fireN1, fireN2, busy, timeout_err, assoc_level
  );

  modport slave (
    input  req_n1, req_n2, adc_drdy, adc_data,
    output adc_start, neuron_12bit, fireN1, fireN2, busy, timeout_err, assoc_level
  );
endinterface

// File: rtl/neuron_fire_scheduler.sv
// neuron_fire_scheduler: arbitrates N1/N2 stimuli for one shared ADC
// conversion, latches the sample onto the neuron bus and opens the matching
// fire window. Optional pairing counter / conditioned response under
// `NEURON_ASSOC_LEARN_EN (undefined: assoc_level tied to 0).
module neuron_fire_scheduler #(
  parameter int FIRE_CYCLES  = 1040,
  parameter int ADC_TIMEOUT  = 255,
  parameter int ASSOC_THRESH = 4
) (
  input  logic                    CLK104MHZ,
  input  logic                    CPU_RESETN,
  neuron_fire_scheduler_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CONVERT, FIRE, GAP} state_t;

  localparam logic [15:0] FIRE_LAST = 16'(FIRE_CYCLES - 1);
  localparam logic [15:0] TO_LAST   = 16'(ADC_TIMEOUT - 1);
  localparam logic [2:0]  ASSOC_TH  = 3'(ASSOC_THRESH);

  state_t       state, state_nxt;
  logic [1:0]   req_q, pend, rise, grant;   // bit0 = N1, bit1 = N2
  logic         cur_gnt;                    // 0 = N1, 1 = N2; doubles as last_grant
  logic [15:0]  cnt;                        // timeout count in CONVERT, window count in FIRE
  logic signed [11:0] sample;
  logic         start_q, tout_q;
  logic [2:0]   assoc;
  logic         conditioned;

  assign rise = {bus.req_n2, bus.req_n1} & ~req_q;

  // Edge detect and one-deep pending flags; a new edge beats the grant clear.
  always_ff @(posedge CLK104MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      req_q <= '0;
      pend  <= '0;
    end else begin
      req_q <= {bus.req_n2, bus.req_n1};
      pend  <= (pend & ~grant) | rise;
    end
  end

  // State register.
  always_ff @(posedge CLK104MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) state <= IDLE;
    else             state <= state_nxt;
  end

  // Next state and grant; a tie goes to the requester not served last.
  always_comb begin
    state_nxt = state;
    grant     = '0;
    case (state)
      IDLE: begin
        if (|pend) begin
          state_nxt = CONVERT;
          if (pend[0] && (!pend[1] || cur_gnt)) grant = 2'b01;
          else                                  grant = 2'b10;
        end
      end
      CONVERT: begin
        if (bus.adc_drdy)        state_nxt = FIRE;
        else if (cnt == TO_LAST) state_nxt = GAP;
      end
      FIRE:    if (cnt == FIRE_LAST) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: grant record, start/timeout pulses, sample latch, phase counter.
  always_ff @(posedge CLK104MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      cur_gnt <= 1'b1;
      cnt     <= '0;
      sample  <= '0;
      start_q <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      start_q <= |grant;
      tout_q  <= (state == CONVERT) && !bus.adc_drdy && (cnt == TO_LAST);
      if (|grant) cur_gnt <= grant[1];
      if (state == CONVERT && bus.adc_drdy) sample <= bus.adc_data;
      // Counter restarts on every state change so each phase counts from 0.
      if (state_nxt != state || state == IDLE) cnt <= '0;
      else                                     cnt <= cnt + 16'd1;
    end
  end

`ifdef NEURON_ASSOC_LEARN_EN
  // Pairing counter: one step per tie arbitration, saturating at 7.
  always_ff @(posedge CLK104MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN)
      assoc <= '0;
    else if (state == IDLE && (&pend) && assoc != 3'd7)
      assoc <= assoc + 3'd1;
  end
`else
  assign assoc = '0;
`endif

  // With assoc tied to 0 and a threshold of at least 1 this is constant 0.
  assign conditioned = (assoc >= ASSOC_TH);

  assign bus.adc_start    = start_q;
  assign bus.timeout_err  = tout_q;
  assign bus.neuron_12bit = sample;
  assign bus.busy         = (state != IDLE);
  assign bus.fireN1       = (state == FIRE) && (!cur_gnt || conditioned);
  assign bus.fireN2       = (state == FIRE) && cur_gnt;
  assign bus.assoc_level  = assoc;
endmodule

// File: tb/tb_neuron_fire_scheduler.sv
// Directed bench for neuron_fire_scheduler (default parameters).
module tb_neuron_fire_scheduler;
  localparam int FC = 1040;
  localparam int TO = 255;
`ifdef NEURON_ASSOC_LEARN_EN
  localparam bit LEARN = 1'b1;
`else
  localparam bit LEARN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  neuron_fire_scheduler_if bus();

  neuron_fire_scheduler #(
    .FIRE_CYCLES(FC), .ADC_TIMEOUT(TO), .ASSOC_THRESH(4)
  ) dut (
    .CLK104MHZ(clk), .CPU_RESETN(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] nb();
    return 32'($unsigned(bus.neuron_12bit));
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_n1 = 1'b0; bus.req_n2 = 1'b0; bus.adc_drdy = 1'b0; bus.adc_data = '0;
    tick(3);
    rst_n = 1'b1;
    tick();
  endtask

  // Wait (bounded) for the conversion-start pulse, then drop the requests.
  task automatic wait_start();
    int k = 0;
    while (!bus.adc_start && k < 40) begin tick(); k++; end
    chk("start_seen", 32'(bus.adc_start), 1);
    bus.req_n1 = 1'b0; bus.req_n2 = 1'b0;
  endtask

  // One full service: start, drdy 3 cycles later, whole window, GAP check.
  // pulse drives request edges at window offsets 100/200/300.
  task automatic serve(input logic [11:0] d, input logic [1:0] pulse, input logic [1:0] exp);
    int n1 = 0, n2 = 0, bad = 0;
    wait_start();
    tick(3);
    bus.adc_drdy = 1'b1; bus.adc_data = d;
    tick();
    bus.adc_drdy = 1'b0; bus.adc_data = '0;
    chk("who", 32'({bus.fireN2, bus.fireN1}), 32'(exp));
    chk("sample", nb(), 32'(d));
    for (int i = 0; i < FC; i++) begin
      if (i == 100 || i == 200 || i == 300) {bus.req_n2, bus.req_n1} = pulse;
      else if (i == 101 || i == 201 || i == 301) {bus.req_n2, bus.req_n1} = 2'b00;
      n1 += int'(bus.fireN1);
      n2 += int'(bus.fireN2);
      if (bus.neuron_12bit != d) bad++;
      tick();
    end
    chk("len_n1", n1, exp[0] ? FC : 0);
    chk("len_n2", n2, exp[1] ? FC : 0);
    chk("stable", bad, 0);
    chk("gap_fire", 32'({bus.fireN2, bus.fireN1}), 0);
  endtask

  initial begin
    int n1, n2, bad, nto, kto, nfire, b255, b256, ns;
    bus.req_n1 = 1'b0; bus.req_n2 = 1'b0; bus.adc_drdy = 1'b0; bus.adc_data = '0;

    // Reset values, during and just after reset.
    tick(2);
    chk("rst_start", 32'(bus.adc_start), 0);
    chk("rst_fire", 32'({bus.fireN2, bus.fireN1}), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_to", 32'(bus.timeout_err), 0);
    chk("rst_data", nb(), 0);
    rst_n = 1'b1;
    tick();
    chk("rel_busy", 32'(bus.busy), 0);
    chk("rel_assoc", 32'(bus.assoc_level), 0);

    // Single N1 with exact cycle timing (cycle 0 = edge cycle).
    bus.req_n1 = 1'b1;
    chk("c0_start", 32'(bus.adc_start), 0);
    tick();
    chk("c1_busy", 32'(bus.busy), 0);
    tick();
    chk("c2_start", 32'(bus.adc_start), 1);
    chk("c2_busy", 32'(bus.busy), 1);
    bus.req_n1 = 1'b0;
    tick();
    chk("c3_start", 32'(bus.adc_start), 0);
    tick(7);
    bus.adc_drdy = 1'b1; bus.adc_data = 12'sh3A5;
    tick();
    bus.adc_drdy = 1'b0; bus.adc_data = '0;
    chk("c11_fire1", 32'(bus.fireN1), 1);
    chk("c11_data", nb(), 32'h3A5);
    n1 = 0; n2 = 0; bad = 0;
    for (int i = 0; i < FC; i++) begin
      n1 += int'(bus.fireN1);
      n2 += int'(bus.fireN2);
      if (nb() != 32'h3A5) bad++;
      tick();
    end
    chk("single_n1", n1, FC);
    chk("single_n2", n2, 0);
    chk("single_stable", bad, 0);
    chk("c1051_fire", 32'(bus.fireN1), 0);
    chk("c1051_busy", 32'(bus.busy), 1);
    tick();
    chk("c1052_busy", 32'(bus.busy), 0);

    // Tie after reset: N1 first; a tie re-armed during its window goes to N2.
    do_reset();
    bus.req_n1 = 1'b1; bus.req_n2 = 1'b1;
    serve(12'h111, 2'b11, 2'b01);
    serve(12'h222, 2'b00, 2'b10);
    serve(12'h0C3, 2'b00, 2'b01);

    // Timeout on a lone N2: one pulse 255 cycles after start, no fire.
    bus.req_n2 = 1'b1;
    wait_start();
    nto = 0; kto = -1; nfire = 0; b255 = -1; b256 = -1;
    for (int off = 1; off <= 300; off++) begin
      tick();
      if (bus.timeout_err) begin nto++; kto = off; end
      if (bus.fireN1 || bus.fireN2) nfire++;
      if (off == 255) b255 = int'(bus.busy);
      if (off == 256) b256 = int'(bus.busy);
    end
    chk("to_count", nto, 1);
    chk("to_at", kto, 255);
    chk("to_nofire", nfire, 0);
    chk("to_busy_gap", b255, 1);
    chk("to_busy_idle", b256, 0);
    chk("to_hold", nb(), 32'h0C3);

    // Drop: three N1 edges during one window give exactly one more service.
    bus.req_n1 = 1'b1;
    serve(12'h7FF, 2'b01, 2'b01);
    serve(12'h800, 2'b00, 2'b01);
    ns = 0;
    for (int i = 0; i < 50; i++) begin
      ns += int'(bus.adc_start);
      tick();
    end
    chk("drop_extra", ns, 0);

    // Asynchronous reset in the middle of an N1 window.
    bus.req_n1 = 1'b1;
    wait_start();
    tick(2);
    bus.adc_drdy = 1'b1; bus.adc_data = 12'h456;
    tick();
    bus.adc_drdy = 1'b0; bus.adc_data = '0;
    tick(50);
    chk("mid_fire", 32'(bus.fireN1), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_fire", 32'(bus.fireN1), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_data", nb(), 0);
    tick(2);
    rst_n = 1'b1;
    tick();
    chk("arst_rel_data", nb(), 0);
    chk("arst_rel_busy", 32'(bus.busy), 0);

    // Pairing: four ties, then a lone bell.
    for (int r = 1; r <= 4; r++) begin
      bus.req_n1 = 1'b1; bus.req_n2 = 1'b1;
      serve(12'(r * 16), 2'b00, 2'b01);
      serve(12'(r * 16 + 1), 2'b00, (LEARN && r == 4) ? 2'b11 : 2'b10);
    end
    chk("assoc_after4", 32'(bus.assoc_level), LEARN ? 4 : 0);
    bus.req_n2 = 1'b1;
    serve(12'h0AA, 2'b00, LEARN ? 2'b11 : 2'b10);
    chk("assoc_final", 32'(bus.assoc_level), LEARN ? 4 : 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
